// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scan encoder.
//   kp_state_t : scan FSM states (SCAN, PDEB, HELD, RDEB)
//   COL_RESET  : column drive pattern after reset (column 0 driven low)
//   ROW_W/COL_W: widths of the row/column fields of the key code
//   col_drive  : active-low one-cold column pattern for a column index
//   first_low  : index of the lowest-numbered low row line
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PDEB,
        HELD,
        RDEB
    } kp_state_t;

    localparam logic [3:0]  COL_RESET = 4'b1110;
    localparam int unsigned ROW_W     = 2;
    localparam int unsigned COL_W     = 2;

    function automatic logic [3:0] col_drive(input logic [COL_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Scans from the top down so the lowest-numbered low row wins.
    function automatic logic [ROW_W-1:0] first_low(input logic [3:0] rows);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!rows[i-1]) r = ROW_W'(i - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the four keypad row lines.
//   CLK   : system clock
//   RST_N : asynchronous active-low reset; outputs idle high (no key)
//   d     : raw row lines from the pins
//   q     : synchronized row lines
module key_sync (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner with press/release debounce and key encoder.
//   CLK       : system clock
//   RST_N     : asynchronous active-low reset
//   ROW       : row lines, pulled up; low = key pressed in driven column
//   COL       : column drive, exactly one bit low
//   D0, D1    : row index of last accepted key (D0 = MSB)
//   Q0, Q1    : column index of last accepted key (Q0 = MSB)
//   KEY_VALID : one-cycle strobe when a debounced press is accepted
//   KEY_HELD  : high from accepted press until debounced release
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 500,
    parameter int unsigned DEB_CNT  = 10000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic       D0,
    output logic       D1,
    output logic       Q0,
    output logic       Q1,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEB_CNT) ? SCAN_DIV : DEB_CNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);

    kp_state_t              state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [COL_W-1:0]       col_idx, col_idx_nxt;
    logic [ROW_W-1:0]       row_idx, row_idx_nxt;
    logic [ROW_W+COL_W-1:0] code, code_nxt;
    logic [3:0]             col_q;
    logic                   valid_q, valid_nxt;
    logic                   held_q, held_nxt;
    logic [3:0]             row_sync;
    logic                   tracked_high;

    key_sync u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (ROW),
        .q     (row_sync)
    );

    // Only the latched row is watched once a key has been picked.
    assign tracked_high = row_sync[row_idx];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        col_idx_nxt = col_idx;
        row_idx_nxt = row_idx;
        code_nxt    = code;
        valid_nxt   = 1'b0;
        held_nxt    = held_q;

        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_nxt = '0;
                    if (row_sync != 4'hF) begin
                        row_idx_nxt = first_low(row_sync);
                        state_nxt   = PDEB;
                    end else begin
                        col_idx_nxt = col_idx + 1'b1;
                    end
                end
            end
            PDEB: begin
                if (tracked_high) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    code_nxt  = {row_idx, col_idx};
                    valid_nxt = 1'b1;
                    held_nxt  = 1'b1;
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end
            end
            HELD: begin
                cnt_nxt = '0;
                if (tracked_high) state_nxt = RDEB;
            end
            RDEB: begin
                if (!tracked_high) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    held_nxt    = 1'b0;
                    col_idx_nxt = col_idx + 1'b1;
                    state_nxt   = SCAN;
                    cnt_nxt     = '0;
                end
            end
            default: begin
                state_nxt = SCAN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= SCAN;
            cnt     <= '0;
            col_idx <= '0;
            row_idx <= '0;
            code    <= '0;
            col_q   <= COL_RESET;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            col_idx <= col_idx_nxt;
            row_idx <= row_idx_nxt;
            code    <= code_nxt;
            col_q   <= col_drive(col_idx_nxt);
            valid_q <= valid_nxt;
            held_q  <= held_nxt;
        end
    end

    assign COL              = col_q;
    assign {D0, D1, Q0, Q1} = code;
    assign KEY_VALID        = valid_q;
    assign KEY_HELD         = held_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
module tb_keypad_scan_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 8;

    localparam int P_SCAN  = 0;
    localparam int P_PRESS = 1;
    localparam int P_HOLD  = 2;
    localparam int P_REL   = 3;

    logic       CLK;
    logic       RST_N;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic       D0, D1, Q0, Q1;
    logic       KEY_VALID;
    logic       KEY_HELD;

    keypad_scan_encoder #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_CNT  (DEB_CNT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ROW       (ROW),
        .COL       (COL),
        .D0        (D0),
        .D1        (D1),
        .Q0        (Q0),
        .Q1        (Q1),
        .KEY_VALID (KEY_VALID),
        .KEY_HELD  (KEY_HELD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // pressed keys, bit index = 4*row + col
    logic [15:0] keys;

    // reference model: timestamps instead of counters
    int         t;
    int         t0;
    int         phase;
    int         m_col;
    int         m_row;
    logic [3:0] m_code;
    logic       m_valid;
    logic       m_held;
    logic [3:0] dly [2];

    // observation helpers
    int         vcount;
    int         hold_col_bad;
    logic [3:0] fall_col;
    logic [3:0] prev_col;
    logic       prev_held;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase   = P_SCAN;
        m_col   = 0;
        m_row   = 0;
        m_code  = '0;
        m_valid = 1'b0;
        m_held  = 1'b0;
        dly[0]  = 4'hF;
        dly[1]  = 4'hF;
        t0      = t;
    endtask

    // One rising edge worth of behaviour; row_in is the pin value captured at that edge.
    task automatic model_step(input logic [3:0] row_in);
        logic [3:0] rs;
        rs      = dly[1];
        dly[1]  = dly[0];
        dly[0]  = row_in;
        m_valid = 1'b0;
        case (phase)
            P_SCAN: begin
                if (t - t0 == SCAN_DIV - 1) begin
                    if (rs != 4'hF) begin
                        for (int i = 3; i >= 0; i--) if (!rs[i]) m_row = i;
                        phase = P_PRESS;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                    t0 = t + 1;
                end
            end
            P_PRESS: begin
                if (rs[m_row]) begin
                    phase = P_SCAN;
                    t0    = t + 1;
                end else if (t - t0 == DEB_CNT - 1) begin
                    m_code  = 4'(m_row * 4 + m_col);
                    m_valid = 1'b1;
                    m_held  = 1'b1;
                    phase   = P_HOLD;
                    t0      = t + 1;
                end
            end
            P_HOLD: begin
                if (rs[m_row]) begin
                    phase = P_REL;
                    t0    = t + 1;
                end
            end
            default: begin
                if (!rs[m_row]) begin
                    phase = P_HOLD;
                    t0    = t + 1;
                end else if (t - t0 == DEB_CNT - 1) begin
                    m_held = 1'b0;
                    m_col  = (m_col + 1) % 4;
                    phase  = P_SCAN;
                    t0     = t + 1;
                end
            end
        endcase
        t++;
    endtask

    // Called at a negedge: drive pins from the key matrix, advance one cycle, compare.
    task automatic step();
        logic [3:0] r;
        logic [3:0] exp_col;
        r = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (keys[k] && !COL[k % 4]) r[k / 4] = 1'b0;
        end
        ROW = r;
        model_step(r);
        @(negedge CLK);
        exp_col = ~(4'b0001 << m_col);
        check_eq("outputs", {6'b0, COL, D0, D1, Q0, Q1, KEY_VALID, KEY_HELD},
                 {6'b0, exp_col, m_code, m_valid, m_held});
        if (KEY_VALID) vcount++;
        if (KEY_HELD && COL != 4'b1110) hold_col_bad++;
        if (prev_held && !KEY_HELD) fall_col = COL;
        prev_held = KEY_HELD;
        prev_col  = COL;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Starts at a negedge; reset is asserted between clock edges.
    task automatic do_reset();
        #2;
        RST_N = 1'b0;
        keys  = '0;
        ROW   = 4'hF;
        #1;
        check_eq("async_reset", {6'b0, COL, D0, D1, Q0, Q1, KEY_VALID, KEY_HELD}, 16'h0380);
        model_reset();
        prev_held = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        logic found;
        t            = 0;
        keys         = '0;
        ROW          = 4'hF;
        RST_N        = 1'b0;
        vcount       = 0;
        hold_col_bad = 0;
        fall_col     = '0;
        prev_held    = 1'b0;
        prev_col     = 4'b1110;
        model_reset();

        repeat (3) @(negedge CLK);
        check_eq("reset_state", {6'b0, COL, D0, D1, Q0, Q1, KEY_VALID, KEY_HELD}, 16'h0380);
        RST_N = 1'b1;

        // 1: idle scanning, then reset mid-dwell
        vcount = 0;
        run(46);
        check_eq("idle_no_valid", 16'(vcount), 16'd0);
        do_reset();

        // 2: clean press row 2 / col 1
        vcount = 0;
        keys   = 16'(1) << 9;
        run(60);
        check_eq("s2_valid_count", 16'(vcount), 16'd1);
        check_eq("s2_code", {12'b0, D0, D1, Q0, Q1}, 16'b1001);
        check_eq("s2_held", {15'b0, KEY_HELD}, 16'd1);
        keys = '0;
        run(30);
        check_eq("s2_released", {15'b0, KEY_HELD}, 16'd0);
        check_eq("s2_resume_col", {12'b0, fall_col}, 16'b1011);
        check_eq("s2_code_kept", {12'b0, D0, D1, Q0, Q1}, 16'b1001);

        // 3: bouncing press on row 0 / col 0, aligned to the start of the col-0 dwell
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (prev_col == 4'b1110 && i > 4) found = 1'b1;
        end
        check_eq("s3_col0_reached", {15'b0, found}, 16'd1);
        vcount = 0;
        keys   = 16'(1);
        run(3);
        keys = '0;
        run(30);
        check_eq("s3_no_valid", 16'(vcount), 16'd0);
        check_eq("s3_code_zero", {12'b0, D0, D1, Q0, Q1}, 16'd0);

        // 4: two keys in column 3; row 0 wins, row 1 found after release
        vcount = 0;
        keys   = (16'(1) << 3) | (16'(1) << 7);
        run(60);
        check_eq("s4_valid_count", 16'(vcount), 16'd1);
        check_eq("s4_code", {12'b0, D0, D1, Q0, Q1}, 16'b0011);
        vcount = 0;
        keys   = 16'(1) << 7;
        run(60);
        check_eq("s4_second_count", 16'(vcount), 16'd1);
        check_eq("s4_second_code", {12'b0, D0, D1, Q0, Q1}, 16'b0111);
        keys = '0;
        run(40);

        // 5: release bounce on row 3 / col 2
        vcount = 0;
        keys   = 16'(1) << 14;
        run(60);
        keys = '0;
        run(4);
        keys = 16'(1) << 14;
        run(20);
        check_eq("s5_still_held", {15'b0, KEY_HELD}, 16'd1);
        keys = '0;
        run(30);
        check_eq("s5_valid_count", 16'(vcount), 16'd1);
        check_eq("s5_released", {15'b0, KEY_HELD}, 16'd0);
        check_eq("s5_code", {12'b0, D0, D1, Q0, Q1}, 16'b1110);

        // 6: long hold of row 1 / col 0
        do_reset();
        vcount       = 0;
        hold_col_bad = 0;
        keys         = 16'(1) << 4;
        run(1000);
        check_eq("s6_valid_count", 16'(vcount), 16'd1);
        check_eq("s6_code", {12'b0, D0, D1, Q0, Q1}, 16'b0100);
        check_eq("s6_col_frozen", 16'(hold_col_bad), 16'd0);
        check_eq("s6_held", {15'b0, KEY_HELD}, 16'd1);
        keys = '0;
        run(30);

        // random key activity against the model
        for (int seg = 0; seg < 80; seg++) begin
            case ($urandom_range(0, 3))
                0:       keys = '0;
                1, 2:    keys = 16'(1) << $urandom_range(0, 15);
                default: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            endcase
            run(int'($urandom_range(1, 40)));
        end
        keys = '0;
        run(40);
        check_eq("final_idle", {15'b0, KEY_HELD}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time and sampling the row lines.
- Debounces key press and key release.
- Produces the 4-line key code {D0,D1,Q0,Q1} plus a one-cycle KEY_VALID strobe.
- Sits between the physical keypad pins and the calculator's key-code-to-BCD decode stage; it is the encoding end of that keypad interface.

Parameters:
- SCAN_DIV, 500: clock cycles each column is driven before its rows are sampled (settling/dwell time); minimum 2.
- DEB_CNT, 10000: consecutive stable cycles required to accept a press or a release; minimum 2.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- ROW  input  4  keypad row lines; pulled up externally; a bit is low when a key in the driven column is pressed.
- COL  output  4  keypad column drive; exactly one bit low at any time.
- D0  output  1  row index MSB.
- D1  output  1  row index LSB.
- Q0  output  1  column index MSB.
- Q1  output  1  column index LSB.
- KEY_VALID  output  1  one-cycle pulse when a debounced press is accepted.
- KEY_HELD  output  1  high from the accepted press until the release is debounced.

Behaviour:
- Key code = 4*row + col. {D0,D1} = row index, {Q0,Q1} = col index, with D0 and Q0 as MSBs.
- Reset (async on RST_N low, takes effect immediately):
  - COL=4'b1110, D0=D1=Q0=Q1=0, KEY_VALID=0, KEY_HELD=0.
  - State SCAN; column index 0; counters 0.
- ROW passes through a 2-flop synchronizer. Every decision below uses the synchronized value (2-cycle input latency).
- State SCAN:
  - Dwell counter runs 0..SCAN_DIV-1. At terminal count, sample synchronized ROW.
  - If any bit is low: latch the lowest-numbered low row (row 0 has highest priority) and the current column. Go to PDEB with counter cleared. COL stays frozen.
  - Otherwise: advance column 0->1->2->3->0 (COL 1110->1101->1011->0111->1110) and clear the counter.
- State PDEB:
  - Each cycle, check the latched row bit.
  - If it is high: return to SCAN on the same column with the counter cleared. No outputs change.
  - If it has been low for DEB_CNT consecutive cycles: register the code onto D0..Q1, pulse KEY_VALID for exactly 1 cycle, set KEY_HELD=1, go to HELD. Code and strobe update on the same edge.
- State HELD:
  - COL stays frozen.
  - When the latched row bit reads high, go to RDEB with counter cleared.
- State RDEB:
  - If the latched row bit reads low: return to HELD.
  - After DEB_CNT consecutive high cycles: KEY_HELD=0, advance to the next column, go to SCAN.
- D0..Q1 hold the last accepted code until the next accepted press; release does not change them.
- Only the latched key is tracked. Other keys pressed meanwhile (other rows or other columns) are ignored until release completes; a key still held then is found on a later scan.
- At most one KEY_VALID per physical press, regardless of hold duration.
- RST_N asserted in any state aborts immediately to reset values. No pulse is generated on reset exit.
- Counter width: $clog2 of the larger of SCAN_DIV and DEB_CNT. Counters saturate-free: they are cleared on every state transition.

Decomposition:
- Shared package keypad_pkg holds:
  - state encoding localparams: SCAN, PDEB, HELD, RDEB;
  - COL_RESET=4'b1110;
  - key-code field widths (ROW_W=2, COL_W=2).
- One natural sub-module: key_sync, a 4-bit two-flop synchronizer with async active-low reset to 4'b1111 (idle, no key).

Test Plan (SCAN_DIV=4, DEB_CNT=8):
1. No keys; release RST_N -> COL cycles 1110,1101,1011,0111,1110 with a 4-cycle dwell each; KEY_VALID never asserts. Assert RST_N mid-dwell -> COL=1110 and all outputs 0 without waiting for a clock edge.
2. Press the key at row 2 / col 1 cleanly (ROW[2] low whenever COL[1] low) -> exactly one KEY_VALID pulse with {D0,D1,Q0,Q1}=1001; KEY_HELD=1. After release, KEY_HELD drops 8 cycles after synchronized ROW[2] goes high; COL resumes at 1011.
3. Bouncing press: ROW[0] low for 3 cycles then high, on col 0 -> no KEY_VALID, code outputs stay 0000, scanning resumes.
4. Keys at row 0 / col 3 and row 1 / col 3 pressed together -> single KEY_VALID with code 0011; the row 1 key is ignored until release completes.
5. Release bounce: after press of row 3 / col 2, ROW[3] goes high for 4 cycles then low again -> KEY_HELD stays 1, no second KEY_VALID. Final clean release -> KEY_HELD=0 after 8 high cycles; code stays 1110.
6. Hold row 1 / col 0 for 1000 cycles -> exactly one KEY_VALID with code 0100; COL stays 1110 for the whole hold.
